spsram_arbiter: RTL and testbench
=================================

Name: spsram_arbiter

Overview:
- Two-requester controller for one single-port synchronous SRAM macro (active-low CSN/WEN/OEN, active-low bit-write-enable BWEN, registered DOUT).
- Arbitrates round-robin between two masters, at most one access per cycle.
- Optionally zero-fills the whole array after reset.
- Returns read data to the winning master through a registered response.

Parameters:
- D_WIDTH, 32, data width of the SRAM and each master.
- A_WIDTH, 10, address width.
- DEPTH, 1024, number of SRAM words. Must be ≤ 2^A_WIDTH.
- CLEAR_ON_RESET, 1. When 1, zero-fill addresses 0..DEPTH-1 after reset. When 0, skip the zero-fill.

Ports:
- CK  in  1  clock, all logic on posedge.
- RST  in  1  synchronous active-high reset.
- m0_req  in  1  master 0 access request.
- m0_we  in  1  1=write, 0=read.
- m0_addr  in  A_WIDTH  address.
- m0_wdata  in  D_WIDTH  write data.
- m0_wmask  in  D_WIDTH  active-high bit write mask.
- m0_gnt  out  1  combinational; access accepted at this edge.
- m0_rvalid  out  1  read data valid pulse.
- m0_rdata  out  D_WIDTH  read data.
- m1_*  same eight ports for master 1.
- sram_csn  out  1  SRAM chip select, active-low.
- sram_wen  out  1  SRAM write enable, active-low.
- sram_oen  out  1  SRAM output enable, active-low.
- sram_a  out  A_WIDTH  SRAM address.
- sram_bwen  out  D_WIDTH  SRAM bit write enable, active-low.
- sram_di  out  D_WIDTH  SRAM write data.
- sram_dout  in  D_WIDTH  SRAM read data, valid the cycle after a read edge.
- init_done  out  1  high once the array is usable.

Behaviour:

State machine (CLEAR, RUN):
- Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
- CLEAR: a counter clr_addr runs 0..DEPTH-1, one write per cycle.
  - SRAM drive: csn=0, wen=0, oen=1, a=clr_addr, bwen=all 0, di=0.
  - After the write at DEPTH-1 the block moves to RUN.
  - Both gnt outputs stay 0 throughout CLEAR.
- RST asserted mid-CLEAR restarts the sweep at address 0.
- RUN is the only state where grants occur.

init_done:
- Registered; reset value 0.
- Goes 1 in the first RUN cycle and stays 1 until the next RST.

Arbitration (RUN only):
- gnt_x = req_x AND (no competing request OR priority pointer = x). Both gnts are combinational from the inputs and state.
- Priority pointer is a 1-bit register; reset value 0 (master 0 favoured).
- After any grant to x, the pointer moves to the other master.
- If only one master requests, it is granted every cycle (back-to-back, no bubbles).
- Masters hold req/we/addr/wdata/wmask stable until their gnt is seen high.

SRAM drive:
- On a granted cycle the SRAM signals come combinationally from the winner:
  - csn=0, a=addr.
  - Write: wen=0, oen=1, bwen=~wmask, di=wdata.
  - Read: wen=1, oen=0, bwen=all 1.
- Idle (no grant, not CLEAR): csn=1, wen=1, oen=1, a=0, bwen=all 1, di=0.

Read response:
- A read accepted at edge E0 sets the internal flags rd_pend=1 and rd_id=winner.
- At E1 the block captures sram_dout into the winner's rdata and pulses its rvalid for exactly one cycle.
- Latency is therefore 2 cycles from the grant edge to rvalid high. Pipelined: one read per cycle sustained.
- rdata holds its last value between pulses.
- Writes produce no response.

Write/read ordering and reset:
- A read to an address written in the previous cycle returns the new data; the SRAM is write-then-read ordered by edge.
- Reset values: all rvalid=0, all rdata=0, pointer=0, rd_pend=0, clr_addr=0, init_done=0.
- A read in flight when RST rises is dropped; no rvalid is produced.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16, RST for 2 cycles:
  - Expect 16 consecutive sram writes, a=0..15, di=0, bwen=0.
  - init_done rises on the 17th cycle after RST falls; no gnt before it.
- Master 0 writes 0xDEADBEEF to addr 5 with wmask=0xFFFF0000, over an array pre-filled with 0x11111111; master 0 then reads addr 5:
  - m0_rvalid pulses 2 cycles after that read grant with rdata=0xDEAD1111.
- Both masters request continuously (reads to addrs 1 and 2): grants alternate m0,m1,m0,m1 starting with m0 after reset; each rvalid lands on the correct master.
- Master 1 alone issues reads to addrs 3,4,5 on consecutive cycles: gnt high 3 cycles back-to-back; m1_rvalid high 3 consecutive cycles with data in order.
- Pulse RST on the cycle after a m0 read grant: no m0_rvalid follows; the CLEAR sweep restarts at address 0.
- CLEAR_ON_RESET=0: init_done=1 and a request is granted in the first cycle after RST falls.

Source files
------------

// File: rtl/spsram_arbiter.sv
// Two-master round-robin arbiter in front of one single-port synchronous SRAM.
// After reset the array can optionally be swept to zero before any grant is given.
// Read data comes back through a registered response two cycles after the grant.
module spsram_arbiter #(
    parameter int D_WIDTH        = 32,
    parameter int A_WIDTH        = 10,
    parameter int DEPTH          = 1024,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic               CK,
    input  logic               RST,
    input  logic               m0_req,
    input  logic               m0_we,
    input  logic [A_WIDTH-1:0] m0_addr,
    input  logic [D_WIDTH-1:0] m0_wdata,
    input  logic [D_WIDTH-1:0] m0_wmask,
    output logic               m0_gnt,
    output logic               m0_rvalid,
    output logic [D_WIDTH-1:0] m0_rdata,
    input  logic               m1_req,
    input  logic               m1_we,
    input  logic [A_WIDTH-1:0] m1_addr,
    input  logic [D_WIDTH-1:0] m1_wdata,
    input  logic [D_WIDTH-1:0] m1_wmask,
    output logic               m1_gnt,
    output logic               m1_rvalid,
    output logic [D_WIDTH-1:0] m1_rdata,
    output logic               sram_csn,
    output logic               sram_wen,
    output logic               sram_oen,
    output logic [A_WIDTH-1:0] sram_a,
    output logic [D_WIDTH-1:0] sram_bwen,
    output logic [D_WIDTH-1:0] sram_di,
    input  logic [D_WIDTH-1:0] sram_dout,
    output logic               init_done
);
    // state    | meaning
    // ST_CLEAR | zero-fill sweep in progress, no grants
    // ST_RUN   | normal arbitration between the two masters
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam state_t             RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    // Without a sweep the first cycle out of reset is already a RUN cycle.
    localparam logic               INIT_RST  = (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic               init_done_q, init_done_d;
    logic               ptr_q, ptr_d;
    logic               rd_pend_q, rd_pend_d;
    logic               rd_id_q, rd_id_d;
    logic               m0_rvalid_q, m0_rvalid_d;
    logic               m1_rvalid_q, m1_rvalid_d;
    logic [D_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [D_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
    logic               gnt0, gnt1;

    // Sweep/arbitration next state, grants and combinational SRAM drive.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        init_done_d = init_done_q;
        ptr_d       = ptr_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        sram_csn    = 1'b1;
        sram_wen    = 1'b1;
        sram_oen    = 1'b1;
        sram_a      = '0;
        sram_bwen   = '1;
        sram_di     = '0;
        unique case (state_q)
            ST_CLEAR: begin
                sram_csn   = 1'b0;
                sram_wen   = 1'b0;
                sram_bwen  = '0;
                sram_a     = clr_addr_q;
                clr_addr_d = clr_addr_q + A_WIDTH'(1);
                if (clr_addr_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                    clr_addr_d  = '0;
                end
            end
            ST_RUN: begin
                init_done_d = 1'b1;
                gnt0 = m0_req && (!m1_req || !ptr_q);
                gnt1 = m1_req && (!m0_req || ptr_q);
                if (gnt0) begin
                    ptr_d     = 1'b1;
                    sram_csn  = 1'b0;
                    sram_a    = m0_addr;
                    sram_wen  = !m0_we;
                    sram_oen  = m0_we;
                    sram_bwen = m0_we ? ~m0_wmask : '1;
                    sram_di   = m0_we ? m0_wdata : '0;
                end else if (gnt1) begin
                    ptr_d     = 1'b0;
                    sram_csn  = 1'b0;
                    sram_a    = m1_addr;
                    sram_wen  = !m1_we;
                    sram_oen  = m1_we;
                    sram_bwen = m1_we ? ~m1_wmask : '1;
                    sram_di   = m1_we ? m1_wdata : '0;
                end
            end
            default: ;
        endcase
        // Nothing is accepted at a reset edge, so keep the macro idle meanwhile.
        if (RST) begin
            gnt0      = 1'b0;
            gnt1      = 1'b0;
            sram_csn  = 1'b1;
            sram_wen  = 1'b1;
            sram_oen  = 1'b1;
            sram_a    = '0;
            sram_bwen = '1;
            sram_di   = '0;
        end
    end

    // Read response pipeline: mark the read at the grant edge, capture DOUT one edge later.
    always_comb begin
        rd_pend_d   = (gnt0 && !m0_we) || (gnt1 && !m1_we);
        rd_id_d     = gnt1;
        m0_rvalid_d = rd_pend_q && !rd_id_q;
        m1_rvalid_d = rd_pend_q && rd_id_q;
        m0_rdata_d  = m0_rvalid_d ? sram_dout : m0_rdata_q;
        m1_rdata_d  = m1_rvalid_d ? sram_dout : m1_rdata_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q     <= RST_STATE;
            clr_addr_q  <= '0;
            init_done_q <= INIT_RST;
            ptr_q       <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_id_q     <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            init_done_q <= init_done_d;
            ptr_q       <= ptr_d;
            rd_pend_q   <= rd_pend_d;
            rd_id_q     <= rd_id_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_spsram_arbiter.sv
// Bench for spsram_arbiter: an SRAM macro model, a cycle-level reference of the
// controller's visible behaviour, directed scenarios and a randomized traffic phase.
module tb_spsram_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] ONES = '1;
    localparam logic [DW-1:0] ZERO = '0;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic RST;
    logic m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_wmask, m0_rdata;
    logic m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_wmask, m1_rdata;
    logic sram_csn, sram_wen, sram_oen, init_done;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_bwen, sram_di, sram_dout;

    spsram_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)) dut (
        .CK(CK), .RST(RST),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wmask(m0_wmask), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wmask(m1_wmask), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .sram_csn(sram_csn), .sram_wen(sram_wen), .sram_oen(sram_oen), .sram_a(sram_a),
        .sram_bwen(sram_bwen), .sram_di(sram_di), .sram_dout(sram_dout), .init_done(init_done)
    );

    // Second instance without the zero-fill sweep.
    logic b_rst;
    logic b_m0_req, b_m0_we, b_m0_gnt, b_m0_rvalid;
    logic [AW-1:0] b_m0_addr;
    logic [DW-1:0] b_m0_wdata, b_m0_wmask, b_m0_rdata;
    logic b_m1_req, b_m1_we, b_m1_gnt, b_m1_rvalid;
    logic [AW-1:0] b_m1_addr;
    logic [DW-1:0] b_m1_wdata, b_m1_wmask, b_m1_rdata;
    logic b_sram_csn, b_sram_wen, b_sram_oen, b_init_done;
    logic [AW-1:0] b_sram_a;
    logic [DW-1:0] b_sram_bwen, b_sram_di, b_sram_dout;

    spsram_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(0)) dut_b (
        .CK(CK), .RST(b_rst),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_wmask(b_m0_wmask), .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_wmask(b_m1_wmask), .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .sram_csn(b_sram_csn), .sram_wen(b_sram_wen), .sram_oen(b_sram_oen), .sram_a(b_sram_a),
        .sram_bwen(b_sram_bwen), .sram_di(b_sram_di), .sram_dout(b_sram_dout), .init_done(b_init_done)
    );
    assign b_sram_dout = ZERO;

    // SRAM macro: write-then-read by edge, registered DOUT.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge CK) begin
        if (!sram_csn) begin
            if (!sram_wen)
                mem[sram_a[3:0]] <= (mem[sram_a[3:0]] & sram_bwen) | (sram_di & ~sram_bwen);
            else if (!sram_oen)
                sram_dout <= mem[sram_a[3:0]];
        end
    end

    // Reference model state.
    typedef struct {int due; int id; logic [DW-1:0] data;} resp_t;
    resp_t rq[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] last_rd [2];
    int  last_served;
    int  clr_left;
    logic exp_init;
    logic exp_gnt [2];
    logic obs_gnt [2];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        last_rd[0]  = '0;
        last_rd[1]  = '0;
        last_served = 1;
        clr_left    = DEPTH;
        exp_init    = 1'b0;
    endtask

    task automatic set_m(input int x, input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] wm);
        if (x == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_wmask = wm;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_wmask = wm;
        end
    endtask

    // One clock cycle: check everything visible against the model, then advance it.
    task automatic tick();
        logic ev, g0, g1, run, fin, gx_we;
        int eid, ca, fav;
        logic [DW-1:0] ed, gx_wd, gx_wm, exp_bwen, merged;
        logic [AW-1:0] gx_a;
        @(negedge CK);
        fin = 1'b0;
        run = (clr_left == 0);
        fav = 1 - last_served;
        g0 = !RST && run && m0_req && (!m1_req || fav == 0);
        g1 = !RST && run && m1_req && (!m0_req || fav == 1);
        exp_gnt[0] = g0;     exp_gnt[1] = g1;
        obs_gnt[0] = m0_gnt; obs_gnt[1] = m1_gnt;
        ev = 1'b0; eid = 0; ed = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            ev = 1'b1; eid = rq[0].id; ed = rq[0].data;
            rq.delete(0);
            last_rd[eid] = ed;
        end
        chk("m0_rvalid", m0_rvalid, ev && eid == 0);
        chk("m1_rvalid", m1_rvalid, ev && eid == 1);
        chk("m0_rdata", m0_rdata, last_rd[0]);
        chk("m1_rdata", m1_rdata, last_rd[1]);
        chk("init_done", init_done, exp_init);
        chk("m0_gnt", m0_gnt, g0);
        chk("m1_gnt", m1_gnt, g1);
        gx_we = g1 ? m1_we : m0_we;
        gx_a  = g1 ? m1_addr : m0_addr;
        gx_wd = g1 ? m1_wdata : m0_wdata;
        gx_wm = g1 ? m1_wmask : m0_wmask;
        if (!RST) begin
            if (!run) begin
                ca = DEPTH - clr_left;
                chk("clr_csn", sram_csn, 1'b0);
                chk("clr_wen", sram_wen, 1'b0);
                chk("clr_oen", sram_oen, 1'b1);
                chk("clr_a", sram_a, AW'(ca));
                chk("clr_bwen", sram_bwen, ZERO);
                chk("clr_di", sram_di, ZERO);
                ref_mem[ca] = '0;
                clr_left--;
                fin = (clr_left == 0);
            end else if (g0 || g1) begin
                chk("acc_csn", sram_csn, 1'b0);
                chk("acc_a", sram_a, gx_a);
                if (gx_we) begin
                    exp_bwen = ~gx_wm;
                    chk("wr_wen", sram_wen, 1'b0);
                    chk("wr_oen", sram_oen, 1'b1);
                    chk("wr_bwen", sram_bwen, exp_bwen);
                    chk("wr_di", sram_di, gx_wd);
                    merged = (ref_mem[gx_a[3:0]] & ~gx_wm) | (gx_wd & gx_wm);
                    ref_mem[gx_a[3:0]] = merged;
                end else begin
                    chk("rd_wen", sram_wen, 1'b1);
                    chk("rd_oen", sram_oen, 1'b0);
                    chk("rd_bwen", sram_bwen, ONES);
                    rq.push_back('{cyc + 2, g1 ? 1 : 0, ref_mem[gx_a[3:0]]});
                end
                last_served = g1 ? 1 : 0;
            end else begin
                chk("idle_csn", sram_csn, 1'b1);
                chk("idle_wen", sram_wen, 1'b1);
                chk("idle_oen", sram_oen, 1'b1);
                chk("idle_a", sram_a, {AW{1'b0}});
                chk("idle_bwen", sram_bwen, ONES);
                chk("idle_di", sram_di, ZERO);
            end
        end
        @(posedge CK);
        if (RST) model_reset();
        else if (fin) exp_init = 1'b1;
        #1;
        cyc++;
    endtask

    // Hold a request until the model says it is granted; bounded wait.
    task automatic access(input int x, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] wm);
        int n;
        n = 0;
        set_m(x, 1'b1, we, addr, wd, wm);
        do begin
            tick();
            n++;
        end while (!exp_gnt[x] && n < 40);
        chk("access_gnt", obs_gnt[x], 1'b1);
        set_m(x, 1'b0, 1'b0, '0, '0, '0);
    endtask

    logic          p_pend [2];
    logic          p_we   [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wd   [2];
    logic [DW-1:0] p_wm   [2];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;
        RST = 1'b1;
        b_rst = 1'b1;
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = '0; b_m0_wdata = '0; b_m0_wmask = '0;
        b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = '0; b_m1_wdata = '0; b_m1_wmask = '0;

        // Reset for two cycles, then a partial sweep interrupted by another reset.
        repeat (2) @(posedge CK);
        #1;
        model_reset();
        RST = 1'b0;
        set_m(0, 1'b1, 1'b1, 10'd0, 32'h1111_1111, ONES);
        repeat (5) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        // Full sweep with m0 already requesting: no grant until init_done.
        repeat (DEPTH) tick();
        chk("init_before_run", init_done, 1'b1);
        set_m(0, 1'b0, 1'b0, '0, '0, '0);

        // Pre-fill, masked write, read back.
        for (int a = 0; a < DEPTH; a++) access(0, 1'b1, AW'(a), 32'h1111_1111, ONES);
        access(0, 1'b1, 10'd5, 32'hDEAD_BEEF, 32'hFFFF_0000);
        access(0, 1'b0, 10'd5, '0, '0);
        repeat (3) tick();
        chk("masked_rdata", m0_rdata, 32'hDEAD_1111);

        // Master 1 alone, three back-to-back reads.
        access(1, 1'b1, 10'd3, 32'h3333_3333, ONES);
        access(1, 1'b1, 10'd4, 32'h4444_4444, ONES);
        for (int k = 0; k < 3; k++) begin
            set_m(1, 1'b1, 1'b0, AW'(3 + k), '0, '0);
            tick();
            chk("m1_b2b_gnt", obs_gnt[1], 1'b1);
        end
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) tick();
        chk("m1_last_rdata", m1_rdata, 32'hDEAD_1111);

        // Reset right after a read grant drops the response and restarts the sweep.
        access(0, 1'b0, 10'd9, '0, '0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        repeat (DEPTH + 1) tick();

        // Contention: alternating grants, responses routed to the right master.
        access(1, 1'b1, 10'd1, 32'hA1A1_A1A1, ONES);
        access(1, 1'b1, 10'd2, 32'hB2B2_B2B2, ONES);
        set_m(0, 1'b1, 1'b0, 10'd1, '0, '0);
        set_m(1, 1'b1, 1'b0, 10'd2, '0, '0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("alt_m0", obs_gnt[0], (k % 2) == 0);
        end
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) tick();
        chk("alt_m0_rdata", m0_rdata, 32'hA1A1_A1A1);
        chk("alt_m1_rdata", m1_rdata, 32'hB2B2_B2B2);

        // Randomized traffic from both masters.
        p_pend[0] = 1'b0;
        p_pend[1] = 1'b0;
        for (int i = 0; i < 400; i++) begin
            for (int x = 0; x < 2; x++) begin
                if (!p_pend[x] && $urandom_range(9) < 6) begin
                    p_pend[x] = 1'b1;
                    p_we[x]   = 1'($urandom_range(1));
                    p_addr[x] = AW'($urandom_range(DEPTH - 1));
                    p_wd[x]   = $urandom;
                    p_wm[x]   = ($urandom_range(2) == 0) ? ONES : $urandom;
                end
                set_m(x, p_pend[x], p_we[x], p_addr[x], p_wd[x], p_wm[x]);
            end
            tick();
            for (int x = 0; x < 2; x++) if (exp_gnt[x]) p_pend[x] = 1'b0;
        end
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) tick();

        // No-sweep instance: usable in the very first cycle after reset.
        b_rst = 1'b0;
        b_m0_req = 1'b1; b_m0_we = 1'b1; b_m0_addr = 10'd7;
        b_m0_wdata = 32'h0BAD_F00D; b_m0_wmask = ONES;
        @(negedge CK);
        chk("b_init_done", b_init_done, 1'b1);
        chk("b_m0_gnt", b_m0_gnt, 1'b1);
        chk("b_sram_a", b_sram_a, 10'd7);
        chk("b_sram_wen", b_sram_wen, 1'b0);
        @(posedge CK);
        #1;
        b_m1_req = 1'b1; b_m1_we = 1'b0; b_m1_addr = 10'd3;
        @(negedge CK);
        chk("b_m0_gnt_2", b_m0_gnt, 1'b0);
        chk("b_m1_gnt_2", b_m1_gnt, 1'b1);
        chk("b_sram_oen", b_sram_oen, 1'b0);
        @(posedge CK);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
